mul_div_seq: RTL and testbench

- Iterative multiply/divide sequencer for the MIPS32 core. Serves MULT, MULTU, DIV, DIVU, MTHI, MTLO and owns the HI/LO registers that MFHI/MFLO read.
- Runs one add/subtract-and-shift step per clock instead of a wide combinational multiplier.
- Sits beside the ALU in the execute stage. The pipeline stalls on busy.

---
 rtl/mul_div_seq_if.sv | 31 +++
 rtl/mul_div_seq.sv | 149 ++++++++++++++
 tb/tb_mul_div_seq.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_seq_if.sv
// Handshake/data bundle between the execute stage and the multiply/divide sequencer.
// Latency: none (wires only).
// Backpressure: the pipeline holds off on busy; the sequencer never stalls its own inputs.
interface mul_div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Pipeline side: issues operations and HI/LO writes, reads results.
  modport master (
    output start, op, a, b, mthi, mtlo, wdata, cancel,
    input  busy, done, hi, lo
  );

  // Sequencer side.
  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Latency: start at E0, one shift step per edge E1..E32, sign fix and HI/LO write at E33.
// Backpressure: busy high while in flight; start/mthi/mtlo ignored then, cancel aborts.
module mul_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  mul_div_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;   // op[1]: divide vs multiply
  logic               neg_q, neg_d;         // product/quotient must be negated
  logic               negr_q, negr_d;       // remainder takes the dividend's (negative) sign
  logic               bz_q, bz_d;           // divisor was zero: quotient sign fix suppressed
  logic [WIDTH-1:0]   opnd_q, opnd_d;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;         // product, or remainder:quotient
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Operand magnitudes and sign flags; op[0] selects the signed variants.
  logic             sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;
  assign sa    = bus.op[0] & bus.a[WIDTH-1];
  assign sb    = bus.op[0] & bus.b[WIDTH-1];
  assign abs_a = sa ? -bus.a : bus.a;
  assign abs_b = sb ? -bus.b : bus.b;

  // One shift-add multiply step: add multiplicand into the upper half when the
  // current multiplier bit is set, then shift the carry-extended accumulator right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring divide step on a WIDTH+1 bit partial remainder.
  logic [WIDTH:0]     rem_sh, diff;
  logic [2*WIDTH-1:0] div_next;
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign diff     = rem_sh - {1'b0, opnd_q};
  assign div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

  // Sign-corrected results applied in FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = (neg_q && !bz_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  // Next-state and datapath update for the IDLE/CALC/FIX sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    bz_d     = bz_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (!bus.cancel) begin
            is_div_d = bus.op[1];
            neg_d    = sa ^ sb;
            negr_d   = sa;
            bz_d     = (bus.b == '0);
            opnd_d   = bus.op[1] ? abs_b : abs_a;
            acc_d    = {{WIDTH{1'b0}}, (bus.op[1] ? abs_a : abs_b)};
            cnt_d    = '0;
            state_d  = CALC;
          end
        end else begin
          if (bus.mthi) hi_d = bus.wdata;
          if (bus.mtlo) lo_d = bus.wdata;
        end
      end
      CALC: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!bus.cancel) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared immediately by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      bz_q     <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      bz_q     <= bz_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Directed bench for mul_div_seq: latency, signed/unsigned results, divide-by-zero,
// overflow, mthi/mtlo, ignored inputs while busy, cancel and asynchronous reset.
module tb_mul_div_seq;
  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  mul_div_seq_if #(.WIDTH(32)) md ();

  mul_div_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation, wait (bounded) for done, check HI/LO and the one-cycle pulse.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    md.start = 1'b1;
    md.op    = op;
    md.a     = a;
    md.b     = b;
    tick();
    md.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (md.done === 1'b1) break;
      tick();
    end
    check({tag, "_done"}, md.done, 1);
    check({tag, "_hi"}, md.hi, exp_hi);
    check({tag, "_lo"}, md.lo, exp_lo);
    tick();
    check({tag, "_done_pulse"}, md.done, 0);
  endtask

  initial begin
    rst       = 1'b1;
    md.start  = 1'b0;
    md.op     = 2'd0;
    md.a      = '0;
    md.b      = '0;
    md.mthi   = 1'b0;
    md.mtlo   = 1'b0;
    md.wdata  = '0;
    md.cancel = 1'b0;
    #3;
    check("rst_busy", md.busy, 0);
    check("rst_done", md.done, 0);
    check("rst_hi", md.hi, 0);
    check("rst_lo", md.lo, 0);
    #9 rst = 1'b0;
    tick();

    // MULTU 0xFFFFFFFF^2 with exact edge timing
    md.start = 1'b1;
    md.op    = 2'd0;
    md.a     = 32'hFFFF_FFFF;
    md.b     = 32'hFFFF_FFFF;
    tick();
    md.start = 1'b0;
    check("t1_busy_e0", md.busy, 1);
    check("t1_done_e0", md.done, 0);
    repeat (32) tick();
    check("t1_busy_e32", md.busy, 1);
    check("t1_done_e32", md.done, 0);
    tick();
    check("t1_busy_e33", md.busy, 0);
    check("t1_done_e33", md.done, 1);
    check("t1_hi", md.hi, 32'hFFFF_FFFE);
    check("t1_lo", md.lo, 32'h0000_0001);
    tick();
    check("t1_done_e34", md.done, 0);

    // Signed multiply/divide
    run_op("mult_m3x7", 2'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_m7d2", 2'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("mult_m5xm6", 2'd1, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0, 32'd30);
    run_op("div_20dm3", 2'd3, 32'd20, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFA);

    // Divide by zero and signed overflow
    run_op("divu_by0", 2'd2, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
    run_op("div_neg_by0", 2'd3, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    run_op("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // MTHI / MTLO in IDLE
    md.mthi  = 1'b1;
    md.wdata = 32'h1234;
    tick();
    md.mthi = 1'b0;
    check("mthi_hi", md.hi, 32'h1234);
    check("mthi_lo_kept", md.lo, 32'h8000_0000);
    md.mtlo  = 1'b1;
    md.wdata = 32'h5678;
    tick();
    md.mtlo = 1'b0;
    check("mtlo_hi_kept", md.hi, 32'h1234);
    check("mtlo_lo", md.lo, 32'h5678);
    md.mthi  = 1'b1;
    md.mtlo  = 1'b1;
    md.wdata = 32'hABCD;
    tick();
    check("mthilo_hi", md.hi, 32'hABCD);
    check("mthilo_lo", md.lo, 32'hABCD);

    // start with mthi in IDLE drops the write; mthi and a new start mid-CALC ignored
    md.mtlo  = 1'b0;
    md.wdata = 32'h9999;
    md.start = 1'b1;
    md.op    = 2'd0;
    md.a     = 32'd3;
    md.b     = 32'd4;
    tick();
    md.start = 1'b0;
    md.mthi  = 1'b0;
    check("start_mthi_busy", md.busy, 1);
    check("start_mthi_hi", md.hi, 32'hABCD);
    repeat (4) tick();
    md.mthi  = 1'b1;
    md.start = 1'b1;
    md.a     = 32'd5;
    md.b     = 32'd5;
    tick();
    md.mthi  = 1'b0;
    md.start = 1'b0;
    check("calc_mthi_hi", md.hi, 32'hABCD);
    for (int i = 0; i < 40; i++) begin
      if (md.done === 1'b1) break;
      tick();
    end
    check("multu_3x4_done", md.done, 1);
    check("multu_3x4_hi", md.hi, 32'd0);
    check("multu_3x4_lo", md.lo, 32'd12);
    tick();

    // cancel in IDLE blocks a same-cycle start
    md.cancel = 1'b1;
    md.start  = 1'b1;
    md.op     = 2'd2;
    md.a      = 32'd50;
    md.b      = 32'd7;
    tick();
    md.start  = 1'b0;
    md.cancel = 1'b0;
    check("idle_cancel_busy", md.busy, 0);

    // cancel mid-CALC
    md.start = 1'b1;
    tick();
    md.start = 1'b0;
    repeat (9) tick();
    check("pre_cancel_busy", md.busy, 1);
    md.cancel = 1'b1;
    tick();
    md.cancel = 1'b0;
    check("cancel_busy", md.busy, 0);
    check("cancel_done", md.done, 0);
    check("cancel_hi", md.hi, 32'd0);
    check("cancel_lo", md.lo, 32'd12);
    run_op("divu_50d7", 2'd2, 32'd50, 32'd7, 32'd1, 32'd7);

    // asynchronous reset mid-CALC
    md.start = 1'b1;
    md.op    = 2'd0;
    md.a     = 32'd9;
    md.b     = 32'd9;
    tick();
    md.start = 1'b0;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_busy", md.busy, 0);
    check("arst_done", md.done, 0);
    check("arst_hi", md.hi, 0);
    check("arst_lo", md.lo, 0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_busy", md.busy, 0);
    run_op("multu_6x7", 2'd0, 32'd6, 32'd7, 32'd0, 32'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
